// File: rtl/compress_pkg.sv
// Shared definitions for the compression pipeline stages.
package compress_pkg;

    // Default data word width used by every compression stage.
    localparam int unsigned COMPRESS_WORD_W = 128;

endpackage

// File: rtl/stage_buffer_compress_if.sv
// Handshake bundle between a compression stage and its holding buffer.
interface stage_buffer_compress_if #(
    parameter int unsigned WIDTH = compress_pkg::COMPRESS_WORD_W,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_word;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_word;
    logic [CNT_W-1:0] o_count;
    logic             o_almost_full;

    // Driver side: upstream producer plus downstream consumer.
    modport master (
        output i_flush, i_valid, i_word, i_ready,
        input  o_ready, o_valid, o_word, o_count, o_almost_full
    );

    // Buffer side.
    modport slave (
        input  i_flush, i_valid, i_word, i_ready,
        output o_ready, o_valid, o_word, o_count, o_almost_full
    );

endinterface

// File: rtl/buffer_mem_compress.sv
// DEPTH x WIDTH flop array: one write port, one combinational read port, no reset.
module buffer_mem_compress #(
    parameter int unsigned WIDTH = compress_pkg::COMPRESS_WORD_W,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stage_buffer_compress.sv
// First-word-fall-through holding buffer between compression stages.
module stage_buffer_compress
    import compress_pkg::*;
#(
    parameter int unsigned WIDTH       = COMPRESS_WORD_W,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    stage_buffer_compress_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_LEVEL);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             afull_q, afull_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] head_word;
    logic             ready;
    logic             valid;
    logic             push;
    logic             pop;

    // Both flags come straight from the registered count, so no path from i_ready to o_ready.
    assign ready = (count_q != CNT_FULL);
    assign valid = (count_q != '0);
    assign push  = bus.i_valid && ready;
    assign pop   = valid && bus.i_ready;

    buffer_mem_compress #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (i_clk),
        .wr_en   (push && !bus.i_flush),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.i_word),
        .rd_addr (rd_ptr_q),
        .rd_data (head_word)
    );

    // Next-state for pointers, count, almost-full and the idle-output hold word.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            hold_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                // Remember the popped word so o_word holds it once the queue empties.
                hold_d   = head_word;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
        afull_d = (count_d >= CNT_AFULL);
    end

    // State registers; synchronous active-low reset overrides flush and handshakes.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            afull_q  <= 1'b0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            afull_q  <= afull_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = valid;
    assign bus.o_count       = count_q;
    assign bus.o_almost_full = afull_q;
    // Storage is only shown while it holds a live word; otherwise the hold register.
    assign bus.o_word        = valid ? head_word : hold_q;

endmodule

// File: tb/tb_stage_buffer_compress.sv
// Directed self-checking bench for stage_buffer_compress (DEPTH=4, WIDTH=128).
module tb_stage_buffer_compress;

    localparam int unsigned WIDTH = 128;
    localparam int unsigned DEPTH = 4;

    logic i_clk = 1'b0;
    logic i_reset;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] nxt;

    stage_buffer_compress_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stage_buffer_compress #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " valid"}, bus.o_valid, 0);
        check({tag, " count"}, bus.o_count, 0);
        check({tag, " word"},  bus.o_word, 0);
        check({tag, " afull"}, bus.o_almost_full, 0);
        check({tag, " ready"}, bus.o_ready, 1);
    endtask

    initial begin
        i_reset     = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_word  = '0;
        bus.i_ready = 1'b0;
        tick();
        tick();
        check_reset_vals("reset");
        i_reset = 1'b1;

        // Reset and fill with downstream stalled.
        for (int k = 1; k <= 4; k++) begin
            bus.i_valid = 1'b1;
            bus.i_word  = WIDTH'(k);
            tick();
            check($sformatf("fill count %0d", k), bus.o_count, k);
            check($sformatf("fill afull %0d", k), bus.o_almost_full, (k >= 3) ? 1 : 0);
            check($sformatf("fill ready %0d", k), bus.o_ready, (k != 4) ? 1 : 0);
            check($sformatf("fill head %0d", k), bus.o_word, 1);
        end
        bus.i_word = 'h5;
        tick();
        check("fifth push ignored", bus.o_count, 4);
        bus.i_valid = 1'b0;

        // Drain order.
        bus.i_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain word %0d", k), bus.o_word, k);
            check($sformatf("drain valid %0d", k), bus.o_valid, 1);
            tick();
        end
        check("drained valid", bus.o_valid, 0);
        check("drained hold word", bus.o_word, 4);
        check("drained count", bus.o_count, 0);
        tick();
        check("hold word stays", bus.o_word, 4);
        bus.i_ready = 1'b0;

        // Preload two words, then stream push+pop.
        for (int k = 0; k < 2; k++) begin
            bus.i_valid = 1'b1;
            bus.i_word  = WIDTH'('h10 + k);
            sb.push_back(bus.i_word);
            tick();
        end
        check("stream preload count", bus.o_count, 2);
        bus.i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nxt = {WIDTH'('hAB00 + k), 64'h0} | WIDTH'('h100 + k);
            bus.i_word = nxt;
            check($sformatf("stream word %0d", k), bus.o_word, sb.pop_front());
            sb.push_back(nxt);
            tick();
            check($sformatf("stream count %0d", k), bus.o_count, 2);
        end

        // Fill to full, then push+pop at full.
        bus.i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.i_word = WIDTH'('h200 + k);
            sb.push_back(bus.i_word);
            tick();
        end
        check("full count", bus.o_count, 4);
        check("full ready", bus.o_ready, 0);
        bus.i_word  = 'hDEAD;
        bus.i_ready = 1'b1;
        check("full pop head", bus.o_word, sb.pop_front());
        tick();
        check("full+pop count", bus.o_count, 3);
        check("full+pop ready rises", bus.o_ready, 1);
        bus.i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("post-full drain %0d", k), bus.o_word, sb.pop_front());
            tick();
        end
        check("post-full empty", bus.o_valid, 0);

        // Flush mid-stream.
        bus.i_ready = 1'b0;
        bus.i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.i_word = WIDTH'('h21 + k);
            tick();
        end
        check("pre-flush count", bus.o_count, 3);
        bus.i_flush = 1'b1;
        bus.i_word  = 'h99;
        tick();
        bus.i_flush = 1'b0;
        bus.i_valid = 1'b0;
        check_reset_vals("flush");
        tick();
        check("flush word never appears", bus.o_valid, 0);
        check("flush word stays 0", bus.o_word, 0);

        // Reset priority over active handshakes.
        bus.i_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.i_word = WIDTH'('h31 + k);
            tick();
        end
        check("pre-reset count", bus.o_count, 2);
        i_reset     = 1'b0;
        bus.i_word  = 'h33;
        bus.i_ready = 1'b1;
        tick();
        check_reset_vals("mid reset");
        i_reset     = 1'b1;
        bus.i_ready = 1'b0;
        bus.i_word  = 'hA;
        tick();
        bus.i_valid = 1'b0;
        check("post-reset push word", bus.o_word, 'hA);
        check("post-reset push valid", bus.o_valid, 1);
        check("post-reset push count", bus.o_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_buffer_compress.md
# stage_buffer_compress

Parametrised, flop-based holding buffer placed between the compression pipeline stages. It replaces the single-entry, enable-gated word latch with a DEPTH-entry, first-word-fall-through queue that uses valid/ready handshaking on both sides. It adds occupancy reporting, an almost-full flag and a synchronous flush. Upstream stages can keep producing while a downstream stage stalls for up to DEPTH words.

## Interface
- WIDTH, 128, data word width in bits.
- DEPTH, 4, number of storage entries; must be a power of two and at least 2.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which o_almost_full asserts; legal range 1..DEPTH.

- i_clk  in  1  clock; all state updates on rising edge.
- i_reset  in  1  reset: i_reset, synchronous, active-low.
- i_flush  in  1  synchronous queue clear, active-high.
- i_valid  in  1  upstream word valid.
- o_ready  out  1  buffer can accept a word this cycle.
- i_word  in  WIDTH  upstream data.
- o_valid  out  1  head word valid.
- i_ready  in  1  downstream accepts the head word.
- o_word  out  WIDTH  head word.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_almost_full  out  1  high when o_count >= AFULL_LEVEL.

## Operation
- Push: i_valid && o_ready. i_word is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: o_valid && i_ready. The read pointer increments modulo DEPTH.
- o_ready = (o_count != DEPTH). It depends only on registered state, with no combinational path from i_ready.
- o_valid = (o_count != 0).
- Count update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
  - neither: unchanged
- Full with push and pop in the same cycle: the push is not accepted, because o_ready=0. The pop completes and the count becomes DEPTH−1.
- Empty: a pop cannot occur. A push makes the word visible on o_word/o_valid in the next cycle; there is no same-cycle bypass.
- Pointer wrap: the pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are decided from o_count, not from pointer equality.
- o_word while o_valid=1: equals the oldest unpopped word.
- o_word while o_valid=0: holds the last word presented. After reset or flush it is 0. It never shows stale storage.
- Flush, cycle N with i_reset=1:
  - Next cycle: count=0, both pointers 0, o_word=0, o_valid=0.
  - Any push or pop in cycle N is discarded.
  - o_ready=1 from cycle N+1.
- Reset, cycle N with i_reset=0: the same effect as flush, and it takes priority over flush and all handshakes. This also applies when reset asserts mid-stream with the buffer partially full.
- Storage array: needs no reset. Every output is still defined from the first cycle after reset.

## Timing
- Reset values of all outputs:
  - o_valid=0, o_count=0, o_word=0.
  - o_almost_full=0 (AFULL_LEVEL ≥ 1).
  - o_ready=1.
- Latency from push to o_valid: 1 cycle.
- Throughput: one push and one pop per cycle, sustained, for any occupancy from 1 to DEPTH−1.
- o_count and o_almost_full are registered and change on the same edge as the count update.
- After a pop when full, o_ready rises in the following cycle.

## Structure
- Shared package compress_pkg holds COMPRESS_WORD_W = 128, which is used as the WIDTH default across stages.
- Pointer and count widths are local parameters derived in the module.
- Sub-module buffer_mem_compress holds the DEPTH×WIDTH flop array:
  - one write port: enable, address, data
  - one combinational read address
- The top level owns the pointers, count, flags and the o_word hold register.
- Target size is about 150–250 lines in total.

## Test plan
- **Reset and fill:** after reset, push 0x1, 0x2, 0x3, 0x4 with i_ready=0 (DEPTH=4).
  - o_count goes 1..4, and o_almost_full rises when o_count=3.
  - o_ready=0 when o_count=4, and a fifth push of 0x5 is ignored.
- **Drain order:** from full, hold i_ready=1. o_word reads 0x1, 0x2, 0x3, 0x4 on consecutive cycles, then o_valid=0 and o_word stays 0x4.
- **Simultaneous push and pop:** with o_count=2, stream pushes and pops every cycle for 20 cycles. o_count stays 2, the data order matches a scoreboard, and the pointers wrap at least 4 times.
- **Full plus pop:** at o_count=4, drive i_valid=1 and i_ready=1. Exactly one word is popped, the push is rejected, and o_count becomes 3.
- **Flush mid-stream:** with o_count=3, assert i_flush together with i_valid. The next cycle shows o_count=0, o_valid=0, o_word=0, and the flushed-cycle word never appears.
- **Reset priority:** with o_count=2, drive i_reset=0 and i_flush=0 with a push and pop active. The next cycle shows all reset values, and a new push of 0xA appears on o_word one cycle after it is accepted.
